// File: rtl/dpram_arb_if.sv
// Two-port request/response bundle for dpram_arb: per-port request, write data,
// handshake ready and read-return signals.
interface dpram_arb_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ready;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ready;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p0_ready, p0_rvalid, p0_rdata,
        input  p1_ready, p1_rvalid, p1_rdata
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p0_ready, p0_rvalid, p0_rdata,
        output p1_ready, p1_rvalid, p1_rdata
    );
endinterface

// File: rtl/dpram_arb.sv
// Arbitrated dual-port RAM: clears itself after reset, then serves two ports with
// read-first semantics; port 0 wins same-address write-write conflicts.
module dpram_arb #(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 3,
    parameter int OUT_REG = 0
) (
    input  logic         clk,
    input  logic         rst,
    dpram_arb_if.slave   bus,
    output logic         init_done,
    output logic         collision
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       init_cnt;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic                    run;
    logic                    conflict;
    logic                    acc0;
    logic                    acc1;
    logic [1:0]              rd_acc;
    logic [1:0]              s1_v;
    logic [1:0]              s2_v;
    logic [1:0][DATA_W-1:0]  s1_data;
    logic [1:0][DATA_W-1:0]  s2_data;
    logic [1:0]              out_v;
    logic [1:0][DATA_W-1:0]  out_d;
    logic                    coll_q;

    // rst gates the combinational handshake so every output is 0 while it is held
    assign run      = (state == RUN) && !rst;
    assign conflict = run && bus.p0_req && bus.p0_we && bus.p1_req && bus.p1_we
                      && (bus.p0_addr == bus.p1_addr);
    assign acc0     = run && bus.p0_req;
    assign acc1     = run && bus.p1_req && !conflict;
    assign rd_acc   = {acc1 && !bus.p1_we, acc0 && !bus.p0_we};

    assign bus.p0_ready = run;
    assign bus.p1_ready = run && !conflict;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[init_cnt] <= '0;
            end else begin
                if (acc0 && bus.p0_we) mem[bus.p0_addr] <= bus.p0_wdata;
                if (acc1 && bus.p1_we) mem[bus.p1_addr] <= bus.p1_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
            s1_v     <= '0;
            s2_v     <= '0;
            s1_data  <= '0;
            s2_data  <= '0;
            coll_q   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + ADDR_W'(1);
                    if (init_cnt == '1) state <= RUN;
                end
                RUN: state <= RUN;
                default: state <= INIT;
            endcase
            coll_q <= conflict;
            // Non-blocking read of mem gives pre-write data on same-edge collisions
            s1_v <= rd_acc;
            if (rd_acc[0]) s1_data[0] <= mem[bus.p0_addr];
            if (rd_acc[1]) s1_data[1] <= mem[bus.p1_addr];
            s2_v <= s1_v;
            if (s1_v[0]) s2_data[0] <= s1_data[0];
            if (s1_v[1]) s2_data[1] <= s1_data[1];
        end
    end

    assign out_v = (OUT_REG != 0) ? s2_v    : s1_v;
    assign out_d = (OUT_REG != 0) ? s2_data : s1_data;

    assign bus.p0_rvalid = out_v[0] && !rst;
    assign bus.p1_rvalid = out_v[1] && !rst;
    assign bus.p0_rdata  = rst ? '0 : out_d[0];
    assign bus.p1_rdata  = rst ? '0 : out_d[1];
    assign init_done     = (state == RUN) && !rst;
    assign collision     = coll_q && !rst;
endmodule

// File: tb/tb_dpram_arb.sv
// Drives identical stimulus into an OUT_REG=0 and an OUT_REG=1 instance and
// scoreboards both against an array-based model of the memory and arbitration rules.
module tb_dpram_arb;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_done0, init_done1, coll0, coll1;

    dpram_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
    dpram_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

    dpram_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .init_done(init_done0), .collision(coll0)
    );
    dpram_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .init_done(init_done1), .collision(coll1)
    );

    assign bus1.p0_req   = bus0.p0_req;
    assign bus1.p0_we    = bus0.p0_we;
    assign bus1.p0_addr  = bus0.p0_addr;
    assign bus1.p0_wdata = bus0.p0_wdata;
    assign bus1.p1_req   = bus0.p1_req;
    assign bus1.p1_we    = bus0.p1_we;
    assign bus1.p1_addr  = bus0.p1_addr;
    assign bus1.p1_wdata = bus0.p1_wdata;

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int fails  = 0;

    // Queue index = instance*2 + port; instance 1 has one extra cycle of latency
    exp_t              sbq [4][$];
    logic [DATA_W-1:0] mmem [DEPTH];
    bit                m_run = 1'b0;
    int                m_idx = 0;
    bit                m_coll_pend = 1'b0;
    bit                exp_init = 1'b0;
    bit                exp_coll = 1'b0;
    bit                mon_en = 1'b0;
    logic [DATA_W-1:0] exp_rd [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_step();
        bit conflict, a0, a1;
        logic [DATA_W-1:0] rv0, rv1;
        if (rst) begin
            for (int i = 0; i < 4; i++) sbq[i].delete();
            m_run = 1'b0;
            m_idx = 0;
            m_coll_pend = 1'b0;
            exp_init = 1'b0;
            exp_coll = 1'b0;
            mon_en = 1'b1;
            chk("p0_ready in reset (dut0)", bus0.p0_ready, 0);
            chk("p1_ready in reset (dut1)", bus1.p1_ready, 0);
        end else begin
            exp_init = m_run;
            exp_coll = m_coll_pend;
            conflict = m_run && bus0.p0_req && bus0.p0_we && bus0.p1_req && bus0.p1_we
                       && (bus0.p0_addr == bus0.p1_addr);
            chk("p0_ready (dut0)", bus0.p0_ready, m_run);
            chk("p1_ready (dut0)", bus0.p1_ready, m_run && !conflict);
            chk("p0_ready (dut1)", bus1.p0_ready, m_run);
            chk("p1_ready (dut1)", bus1.p1_ready, m_run && !conflict);
            a0  = m_run && bus0.p0_req;
            a1  = m_run && bus0.p1_req && !conflict;
            rv0 = mmem[bus0.p0_addr];
            rv1 = mmem[bus0.p1_addr];
            for (int k = 0; k < 2; k++) begin
                if (a0 && !bus0.p0_we) sbq[k*2+0].push_back('{cycle + 1 + k, rv0});
                if (a1 && !bus0.p1_we) sbq[k*2+1].push_back('{cycle + 1 + k, rv1});
            end
            if (a0 && bus0.p0_we) mmem[bus0.p0_addr] = bus0.p0_wdata;
            if (a1 && bus0.p1_we) mmem[bus0.p1_addr] = bus0.p1_wdata;
            m_coll_pend = conflict;
            if (!m_run) begin
                mmem[m_idx] = '0;
                m_idx++;
                if (m_idx == DEPTH) m_run = 1'b1;
            end
        end
    endtask

    function automatic logic get_v(input int i);
        case (i)
            0: return bus0.p0_rvalid;
            1: return bus0.p1_rvalid;
            2: return bus1.p0_rvalid;
            default: return bus1.p1_rvalid;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] get_d(input int i);
        case (i)
            0: return bus0.p0_rdata;
            1: return bus0.p1_rdata;
            2: return bus1.p0_rdata;
            default: return bus1.p1_rdata;
        endcase
    endfunction

    always @(negedge clk) begin
        logic v;
        logic [DATA_W-1:0] d;
        exp_t e;
        #2;
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                v = get_v(i);
                d = get_d(i);
                if (rst) exp_rd[i] = '0;
                if (v) begin
                    if (sbq[i].size() == 0) begin
                        chk($sformatf("unexpected rvalid[%0d]", i), v, 0);
                    end else begin
                        e = sbq[i].pop_front();
                        chk($sformatf("rvalid timing[%0d]", i), cycle, e.due);
                        exp_rd[i] = e.data;
                    end
                end else if (sbq[i].size() != 0 && sbq[i][0].due <= cycle) begin
                    e = sbq[i].pop_front();
                    chk($sformatf("missing rvalid[%0d]", i), v, 1);
                end
                chk($sformatf("rdata[%0d]", i), d, exp_rd[i]);
            end
            chk("init_done (dut0)", init_done0, exp_init);
            chk("init_done (dut1)", init_done1, exp_init);
            chk("collision (dut0)", coll0, exp_coll);
            chk("collision (dut1)", coll1, exp_coll);
        end
    end

    task automatic drive(input bit r,
                         input bit q0, input bit w0, input int a0, input int d0,
                         input bit q1, input bit w1, input int a1, input int d1);
        @(negedge clk);
        rst           = r;
        bus0.p0_req   = q0;
        bus0.p0_we    = w0;
        bus0.p0_addr  = ADDR_W'(a0);
        bus0.p0_wdata = DATA_W'(d0);
        bus0.p1_req   = q1;
        bus0.p1_we    = w1;
        bus0.p1_addr  = ADDR_W'(a1);
        bus0.p1_wdata = DATA_W'(d1);
        #1 model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit r, q0, w0, q1, w1;
        int a0, a1;
        bus0.p0_req = 1'b0; bus0.p0_we = 1'b0; bus0.p0_addr = '0; bus0.p0_wdata = '0;
        bus0.p1_req = 1'b0; bus0.p1_we = 1'b0; bus0.p1_addr = '0; bus0.p1_wdata = '0;
        for (int i = 0; i < 4; i++) exp_rd[i] = '0;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(8);
        for (int a = 0; a < DEPTH; a++) drive(0, 1, 0, a, 0, 1, 0, DEPTH - 1 - a, 0);
        idle(2);

        drive(0, 1, 1, 3, 'hA, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 3, 0);
        idle(2);

        drive(0, 1, 1, 5, 'h6, 1, 1, 5, 'h9);
        drive(0, 0, 0, 0, 0, 1, 1, 5, 'h9);
        drive(0, 1, 0, 5, 0, 0, 0, 0, 0);
        idle(2);

        drive(0, 1, 1, 2, 'h4, 0, 0, 0, 0);
        drive(0, 1, 1, 2, 'hF, 1, 0, 2, 0);
        drive(0, 1, 0, 2, 0, 1, 0, 2, 0);
        idle(2);

        for (int a = 0; a < 4; a++) drive(0, 1, 1, a, a + 1, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) drive(0, 1, 0, a, 0, 0, 0, 0, 0);
        idle(3);

        drive(0, 1, 1, 6, 'h7, 0, 0, 0, 0);
        drive(0, 1, 0, 6, 0, 1, 0, 6, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(8);
        for (int a = 0; a < DEPTH; a++) drive(0, 1, 0, a, 0, 0, 0, 0, 0);
        idle(2);

        repeat (3000) begin
            r  = ($urandom_range(0, 299) == 0);
            q0 = $urandom_range(0, 2) != 0;
            q1 = $urandom_range(0, 2) != 0;
            w0 = $urandom_range(0, 1) != 0;
            w1 = $urandom_range(0, 1) != 0;
            a0 = $urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 1);
            a1 = $urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 1);
            drive(r, q0, w0, a0, $urandom_range(0, 15), q1, w1, a1, $urandom_range(0, 15));
        end
        idle(4);
        for (int i = 0; i < 4; i++) chk($sformatf("scoreboard drained[%0d]", i), sbq[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/dpram_arb.md
DPRAM_ARB -- requirements
Module: dpram_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 4, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W words, derived internally.
REQ-003 SHALL have parameter OUT_REG, default 0; 0 = read latency 1, 1 = read latency 2.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports p0_req / p1_req  input  1  port request.
REQ-007 SHALL have ports p0_we / p1_we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 SHALL have ports p0_addr / p1_addr  input  ADDR_W  word address.
REQ-009 SHALL have ports p0_wdata / p1_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports p0_ready / p1_ready  output  1  request accepted this cycle when req & ready.
REQ-011 SHALL have ports p0_rvalid / p1_rvalid  output  1  one-cycle pulse, read data valid.
REQ-012 SHALL have ports p0_rdata / p1_rdata  output  DATA_W  read data.
REQ-013 SHALL have port init_done  output  1  memory clear complete.
REQ-014 SHALL have port collision  output  1  one-cycle pulse, write-write conflict arbitrated.

Function
REQ-015 SHALL implement a two-state FSM, INIT and RUN; reset enters INIT.
REQ-016 In INIT, SHALL write zero to one location per cycle, addresses 0..DEPTH-1, using an ADDR_W-bit counter; after address DEPTH-1 is written, SHALL enter RUN. RUN is reached DEPTH cycles after rst deasserts.
REQ-017 init_done SHALL be 0 in INIT and 1 in RUN.
REQ-018 p0_ready and p1_ready SHALL be 0 in INIT; requests made during INIT are dropped, not queued.
REQ-019 In RUN, p0_ready SHALL always be 1.
REQ-020 In RUN, p1_ready SHALL be 1 except in a write-write conflict: p0_req & p0_we & p1_req & p1_we & (p0_addr == p1_addr).
REQ-021 In a conflict, port 0's write SHALL be performed and p1_ready SHALL be 0. collision SHALL pulse 1 on the following cycle. Port 1 holds its request and is accepted once the conflict clears.
REQ-022 An accepted write SHALL update memory at the clock edge. A write produces no rvalid.
REQ-023 An accepted read SHALL pulse rvalid exactly once: 1 cycle after acceptance when OUT_REG=0, 2 cycles after when OUT_REG=1. Back-to-back reads SHALL be accepted every cycle, fully pipelined.
REQ-024 Reads SHALL be read-first: a read accepted in the same cycle as a write to the same address, from either port, returns the pre-write data.
REQ-025 Both ports reading the same address in the same cycle SHALL both be accepted and return identical data.
REQ-026 A write on one port and a read on the other to different addresses SHALL both be accepted.
REQ-027 prdata SHALL hold its last value while rvalid is 0.
REQ-028 collision SHALL be 0 in any cycle not following a conflict.

Reset
REQ-029 rst SHALL have priority over all other inputs.
REQ-030 While rst=1, all outputs SHALL be 0, the FSM SHALL be in INIT, the init counter 0 and pipeline valid bits cleared.
REQ-031 Reset asserted mid-operation SHALL discard in-flight reads (no rvalid) and rerun the full INIT clear.
REQ-032 Memory contents SHALL be zero after every INIT completes.

Verification
REQ-033 rst 1 cycle, then idle, defaults -> init_done=0 for 8 cycles then 1; reads of all 8 addresses return 0.
REQ-034 p0 write addr 3 data 0xA, next cycle p1 read addr 3, OUT_REG=0 -> p1_rvalid=1 one cycle later, p1_rdata=0xA.
REQ-035 Both ports write addr 5, p0 data 0x6, p1 data 0x9, same cycle -> p1_ready=0, collision pulse next cycle; p1 accepted next cycle; final read of addr 5 = 0x9.
REQ-036 Addr 2 holds 0x4; p0 writes 0xF to addr 2 while p1 reads addr 2, same cycle -> p1_rdata=0x4; a later read returns 0xF.
REQ-037 OUT_REG=1, p0 reads 4 consecutive addresses 0..3 holding 1,2,3,4 -> rvalid high for 4 consecutive cycles starting 2 cycles after the first request, data 1,2,3,4.
REQ-038 Issue a read, assert rst the next cycle -> no rvalid, init_done=0, previously written data reads back 0 after INIT.
